// File: rtl/booth_mul_scheduler_if.sv
// Request, shared-multiplier and response signals of booth_mul_scheduler.
`timescale 1ns/1ps

interface booth_mul_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_res;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_res, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_res, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, busy
    );
endinterface

// File: rtl/booth_mul_scheduler.sv
// Round-robin scheduler sharing one combinational Booth multiplier among NREQ requesters.
// Define BOOTH_SCHED_MUL_PIPE_EN to register the product in an extra SM stage.
`timescale 1ns/1ps

module booth_mul_scheduler #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_mul_scheduler_if.slave bus
);

    logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]            gnt_oh;
    logic [IDW-1:0]             gnt_idx;
    logic                       gnt_vld;
    logic [WIDTH-1:0]           gnt_a, gnt_b;
    logic                       adv1, adv2, accept;

    logic                       v1_q, v1_d;
    logic signed [WIDTH-1:0]    s1_a_q, s1_a_d;
    logic signed [WIDTH-1:0]    s1_b_q, s1_b_d;
    logic [IDW-1:0]             s1_id_q, s1_id_d;

    logic                       v2_q, v2_d;
    logic signed [2*WIDTH-1:0]  s2_prod_q, s2_prod_d;
    logic [IDW-1:0]             s2_id_q, s2_id_d;

    logic                       s2_src_v;
    logic signed [2*WIDTH-1:0]  s2_src_prod;
    logic [IDW-1:0]             s2_src_id;

`ifdef BOOTH_SCHED_MUL_PIPE_EN
    logic                       advm;
    logic                       vm_q, vm_d;
    logic signed [2*WIDTH-1:0]  sm_prod_q, sm_prod_d;
    logic [IDW-1:0]             sm_id_q, sm_id_d;
`endif

    // Search from rr_ptr+1 upward with wrap; the pointer itself is checked last.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_vld && bus.req_valid[i] &&
                    (i == ((int'(rr_ptr_q) + k) % NREQ))) begin
                    gnt_vld   = 1'b1;
                    gnt_oh[i] = 1'b1;
                    gnt_idx   = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                gnt_a = bus.req_a[i*WIDTH +: WIDTH];
                gnt_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign adv2 = !v2_q || bus.rsp_ready;
`ifdef BOOTH_SCHED_MUL_PIPE_EN
    assign advm = !vm_q || adv2;
    assign adv1 = !v1_q || advm;
`else
    assign adv1 = !v1_q || adv2;
`endif
    assign accept = gnt_vld && adv1;

    // S1: operand register feeding the shared multiplier
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        v1_d     = v1_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_id_d  = s1_id_q;
        if (accept) begin
            rr_ptr_d = gnt_idx;
        end
        if (adv1) begin
            v1_d = accept;
            if (accept) begin
                s1_a_d  = $signed(gnt_a);
                s1_b_d  = $signed(gnt_b);
                s1_id_d = gnt_idx;
            end
        end
    end

`ifdef BOOTH_SCHED_MUL_PIPE_EN
    // SM: registered multiplier result
    always_comb begin
        vm_d      = vm_q;
        sm_prod_d = sm_prod_q;
        sm_id_d   = sm_id_q;
        if (advm) begin
            vm_d      = v1_q;
            sm_prod_d = $signed(bus.mul_res);
            sm_id_d   = s1_id_q;
        end
    end

    assign s2_src_v    = vm_q;
    assign s2_src_prod = sm_prod_q;
    assign s2_src_id   = sm_id_q;
`else
    assign s2_src_v    = v1_q;
    assign s2_src_prod = $signed(bus.mul_res);
    assign s2_src_id   = s1_id_q;
`endif

    // S2: result register presented to the consumer
    always_comb begin
        v2_d      = v2_q;
        s2_prod_d = s2_prod_q;
        s2_id_d   = s2_id_q;
        if (adv2) begin
            v2_d      = s2_src_v;
            s2_prod_d = s2_src_prod;
            s2_id_d   = s2_src_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= IDW'(NREQ - 1);
            v1_q      <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_id_q   <= '0;
            v2_q      <= 1'b0;
            s2_prod_q <= '0;
            s2_id_q   <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            v1_q      <= v1_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_id_q   <= s1_id_d;
            v2_q      <= v2_d;
            s2_prod_q <= s2_prod_d;
            s2_id_q   <= s2_id_d;
        end
    end

`ifdef BOOTH_SCHED_MUL_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vm_q      <= 1'b0;
            sm_prod_q <= '0;
            sm_id_q   <= '0;
        end else begin
            vm_q      <= vm_d;
            sm_prod_q <= sm_prod_d;
            sm_id_q   <= sm_id_d;
        end
    end
`endif

    // The grant is combinational, so it is masked while reset holds the pipeline empty.
    assign bus.req_ready = (rst_n && adv1) ? gnt_oh : '0;
    assign bus.mul_a     = s1_a_q;
    assign bus.mul_b     = s1_b_q;
    assign bus.rsp_valid = v2_q;
    assign bus.rsp_prod  = s2_prod_q;
    assign bus.rsp_id    = s2_id_q;
`ifdef BOOTH_SCHED_MUL_PIPE_EN
    assign bus.busy      = v1_q || vm_q || v2_q;
`else
    assign bus.busy      = v1_q || v2_q;
`endif

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Scoreboard bench for booth_mul_scheduler with a signed multiplier model on mul_res.
`timescale 1ns/1ps

module tb_booth_mul_scheduler;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
`ifdef BOOTH_SCHED_MUL_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [IDW-1:0]     id;
        logic [2*WIDTH-1:0] prod;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    booth_mul_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    booth_mul_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared datapath: sign-extend and keep the low 2*WIDTH bits.
    assign bus.mul_res = {{WIDTH{bus.mul_a[WIDTH-1]}}, bus.mul_a} *
                         {{WIDTH{bus.mul_b[WIDTH-1]}}, bus.mul_b};

    int errs = 0;
    int checks = 0;
    int ncyc = 0;
    int rsp_cnt = 0;
    int mp = NREQ - 1;
    int pend [NREQ];
    exp_t sb [$];
    int id_log [$];
    int stamp_log [$];
    logic [NREQ-1:0] acc_mask;
    logic rsp_hs;
    logic hold_prev;
    logic [IDW-1:0] hold_id;
    logic [2*WIDTH-1:0] hold_prod;
    logic [IDW-1:0] last_id;
    logic [2*WIDTH-1:0] last_prod;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] exp_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0]   sa;
        logic signed [WIDTH-1:0]   sbv;
        logic signed [2*WIDTH-1:0] p;
        sa  = a;
        sbv = b;
        p   = sa * sbv;
        return p;
    endfunction

    task automatic monitor();
        int eg;
        int idx;
        logic [IDW-1:0] ix;
        logic [NREQ-1:0] v;
        exp_t e;
        acc_mask = '0;
        rsp_hs   = 1'b0;
        if (!rst_n) return;
        eg = -1;
        v  = bus.req_valid;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (mp + k) % NREQ;
            ix  = IDW'(idx);
            if (eg < 0 && v[ix]) eg = idx;
        end
        if (|bus.req_ready) chk("ready_onehot", 64'($countones(bus.req_ready)), 64'(1));
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                acc_mask[i] = 1'b1;
                chk("grant_id", 64'(i), 64'(eg));
                e.id   = IDW'(i);
                e.prod = exp_mul(bus.req_a[i*WIDTH +: WIDTH], bus.req_b[i*WIDTH +: WIDTH]);
                sb.push_back(e);
                mp = i;
            end
        end
        if (hold_prev) begin
            chk("hold_valid", 64'(bus.rsp_valid), 64'(1));
            chk("hold_id", 64'(bus.rsp_id), 64'(hold_id));
            chk("hold_prod", 64'(bus.rsp_prod), 64'(hold_prod));
        end
        hold_prev = bus.rsp_valid && !bus.rsp_ready;
        hold_id   = bus.rsp_id;
        hold_prod = bus.rsp_prod;
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_hs = 1'b1;
            rsp_cnt++;
            id_log.push_back(int'(bus.rsp_id));
            stamp_log.push_back(ncyc);
            last_id   = bus.rsp_id;
            last_prod = bus.rsp_prod;
            if (sb.size() == 0) begin
                chk("stale_rsp", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                chk("rsp_prod", 64'(bus.rsp_prod), 64'(e.prod));
            end
        end
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic add_req(input int i, input int n);
        pend[i] = n;
        bus.req_valid[i] = 1'b1;
        set_ops(i, WIDTH'($urandom), WIDTH'($urandom));
    endtask

    // One cycle: sample on the falling edge, update requesters just after the rising edge.
    task automatic step();
        ncyc++;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) begin
                pend[i]--;
                if (pend[i] <= 0) bus.req_valid[i] = 1'b0;
                else set_ops(i, WIDTH'($urandom), WIDTH'($urandom));
            end
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((bus.busy || (|bus.req_valid) || sb.size() != 0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) chk("idle_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_at;
        int rsp_at;
        int c0;
        int l0;
        int n1;
        logic [IDW-1:0] sid;
        logic [2*WIDTH-1:0] sprod;

        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        hold_prev     = 1'b0;
        acc_mask      = '0;
        rsp_hs        = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_mul_a", 64'(bus.mul_a), 64'(0));
        chk("rst_mul_b", 64'(bus.mul_b), 64'(0));
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request: latency and signed product
        bus.rsp_ready = 1'b1;
        add_req(0, 1);
        set_ops(0, 16'h0003, 16'hFFFE);
        acc_at = -100;
        rsp_at = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (acc_mask[0]) acc_at = ncyc;
            if (rsp_hs) begin
                rsp_at = ncyc;
                break;
            end
        end
        chk("t1_latency", 64'(rsp_at - acc_at), 64'(LAT));
        chk("t1_id", 64'(last_id), 64'(0));
        chk("t1_prod", 64'(last_prod), 64'(32'hFFFFFFFA));
        wait_idle(50);

        // All requesters busy: round-robin order, one result per cycle
        c0 = rsp_cnt;
        l0 = id_log.size();
        for (int i = 0; i < NREQ; i++) add_req(i, 3);
        wait_idle(200);
        chk("t2_count", 64'(rsp_cnt - c0), 64'(12));
        if (id_log.size() >= l0 + 12) begin
            for (int j = 0; j < 12; j++) chk("t2_order", 64'(id_log[l0 + j]), 64'((j + 1) % NREQ));
            chk("t2_throughput", 64'(stamp_log[l0 + 11] - stamp_log[l0]), 64'(11));
        end else begin
            chk("t2_log_size", 64'(id_log.size() - l0), 64'(12));
        end

        // Backpressure with three pending requests
        bus.rsp_ready = 1'b0;
        c0 = rsp_cnt;
        add_req(0, 1);
        add_req(1, 1);
        add_req(2, 1);
        repeat (5) step();
        chk("t3_ready_zero", 64'(bus.req_ready), 64'(0));
        chk("t3_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("t3_busy", 64'(bus.busy), 64'(1));
        sid   = bus.rsp_id;
        sprod = bus.rsp_prod;
        step();
        chk("t3_stable_id", 64'(bus.rsp_id), 64'(sid));
        chk("t3_stable_prod", 64'(bus.rsp_prod), 64'(sprod));
        bus.rsp_ready = 1'b1;
        wait_idle(100);
        chk("t3_count", 64'(rsp_cnt - c0), 64'(3));

        // Wrap search with the pointer sitting on the only requester
        add_req(2, 1);
        wait_idle(50);
        add_req(2, 1);
        #1;
        chk("t4_wrap_grant", 64'(bus.req_ready), 64'(4'b0100));
        wait_idle(50);

        // Reset mid-operation discards in-flight work
        bus.rsp_ready = 1'b0;
        add_req(0, 1);
        add_req(1, 1);
        add_req(2, 1);
        repeat (4) step();
        chk("t5_busy_pre", 64'(bus.busy), 64'(1));
        chk("t5_valid_pre", 64'(bus.rsp_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("t5_busy", 64'(bus.busy), 64'(0));
        chk("t5_ready", 64'(bus.req_ready), 64'(0));
        sb.delete();
        mp = NREQ - 1;
        hold_prev = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        bus.rsp_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        c0 = rsp_cnt;
        step();
        chk("t5_no_stale", 64'(rsp_cnt - c0), 64'(0));
        add_req(0, 1);
        add_req(3, 1);
        #1;
        chk("t5_first_grant", 64'(bus.req_ready), 64'(4'b0001));
        wait_idle(50);
        chk("t5_count", 64'(rsp_cnt - c0), 64'(2));

        // Requester 1 withdraws while stalled; requester 3 wins
        l0 = id_log.size();
        bus.rsp_ready = 1'b0;
        add_req(0, LAT);
        repeat (LAT + 2) step();
        add_req(1, 1);
        add_req(3, 1);
        #1;
        chk("t6_stalled", 64'(bus.req_ready), 64'(0));
        repeat (2) step();
        bus.req_valid[1] = 1'b0;
        pend[1] = 0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("t6_grant3", 64'(bus.req_ready), 64'(4'b1000));
        wait_idle(50);
        n1 = 0;
        for (int j = l0; j < id_log.size(); j++) if (id_log[j] == 1) n1++;
        chk("t6_no_id1", 64'(n1), 64'(0));
        add_req(0, 1);
        add_req(1, 1);
        #1;
        chk("t6_ptr_at3", 64'(bus.req_ready), 64'(4'b0001));
        wait_idle(50);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
